clock_step_ctrl: RTL and testbench
==================================

Name: clock_step_ctrl

Overview:
- Parametrised clock-enable controller for the processor core.
- Generates the single-cycle `clk_en` pulse that advances the processor. It replaces the fixed divided-clock approach.
- Supports three kinds of progress:
  - free-running at a programmable divide ratio;
  - single-step on a debounced `enter` press;
  - stall on input-instruction and halt opcodes until the operator presses `enter`.
- Sits between the board clock/buttons and the processor. The processor runs on `clock` and gates its state updates with `clk_en`.

Parameters:
- DIV_W, 26, width of the divide counter.
- DIV_DEFAULT, 25000000, divide ratio applied while `div_load` is never asserted (minimum 2).
- DEB_CYCLES, 500000, number of stable-level cycles required to accept an `enter` level change.
- OP_W, 6, opcode width.
- OP_IN, 6'h1A, input instruction opcode; stalls until `enter` is pressed.
- OP_HALT, 6'h3F, halt opcode; stops until reset or a `resume` press.

Ports:
- clock, in, 1, system clock (50 MHz).
- reset, in, 1, asynchronous active-low reset.
- enter, in, 1, raw push-button, active-low, asynchronous to `clock`.
- step_mode, in, 1, 1 = single-step mode; 0 = free-run mode.
- resume, in, 1, level input, sampled only in HALT; a debounced `enter` press with `resume`=1 leaves HALT.
- div_load, in, 1, one-cycle strobe that loads `div_value`.
- div_value, in, DIV_W, new divide ratio; values 0 and 1 are clamped to 2.
- opcode, in, OP_W, opcode of the instruction currently held by the processor.
- clk_en, out, 1, one-cycle processor advance pulse.
- waiting, out, 1, 1 while stalled in IO_WAIT (drives the LED).
- halted, out, 1, 1 in HALT.
- press, out, 1, one-cycle debounced press pulse, also used by the processor to latch `switches`.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - outputs: `clk_en`=0, `waiting`=0, `halted`=0, `press`=0;
  - state = RUN, divider count = 0, div_reg = DIV_DEFAULT;
  - debounced level = 1 (released), debounce count = 0.
  - Reset mid-stall or mid-debounce discards everything.
  - Release is applied on the next `clock` edge; no output may glitch high on release.
- Input path:
  - 2-flop synchroniser on `enter`.
  - The debounce counter counts while the synchronised level differs from the debounced level; it clears when they are equal.
  - At DEB_CYCLES-1 the debounced level flips.
  - `press` = 1 for one cycle on the debounced 1→0 transition only, 3 + DEB_CYCLES cycles after a clean press. Release produces no pulse.
- Divider:
  - Counts 0 .. div_reg-1 and emits `tick` at div_reg-1, then wraps to 0.
  - `div_load` sets div_reg (clamped) and clears the count. If `div_load` and a wrap fall in the same cycle, the load wins and no tick is emitted.
  - The divider runs only in RUN with `step_mode`=0. In every other state it is held at 0.
- FSM (registered; `clk_en` is a registered output):
  - RUN:
    - `step_mode`=0: `clk_en` = `tick`.
    - `step_mode`=1: `clk_en` = `press`.
    - After each `clk_en` the opcode is re-examined on the following cycle (`opcode` must be valid one cycle after `clk_en`). OP_HALT → HALT; OP_IN → IO_WAIT.
  - IO_WAIT:
    - `waiting`=1, `clk_en`=0.
    - `press` → `clk_en`=1 for one cycle and `waiting` clears in the same cycle; next state is RUN.
    - A press in this state is consumed by the wait and does not also count as a step.
  - HALT:
    - `halted`=1, `clk_en`=0.
    - `press` with `resume`=1 → RUN with no `clk_en`; the processor is re-examined only after the next advance.
    - `press` with `resume`=0 is ignored.
- Simultaneous events:
  - When the opcode check and `press` fall in the same cycle, the opcode check wins: the FSM enters the wait/halt state and that press is dropped.
  - `step_mode` changes take effect on the next cycle. Switching to step mode clears the divider count.
- `clk_en` is never high on two consecutive cycles, except when div_reg=2 in free-run (a tick every other cycle, so still non-consecutive).

Decomposition:
- Shared package `proc_pkg`:
  - opcode constants OP_IN and OP_HALT;
  - state enum {RUN, IO_WAIT, HALT}.
- One sub-module, `button_debounce` (synchroniser + debounce counter + press pulse, parameter DEB_CYCLES). It is reused for the `reset`/`interruption` keys elsewhere.
- The divider and FSM stay inline.

Test Plan:
All scenarios use DEB_CYCLES=4 and DIV_DEFAULT=5.
- Reset, then free-run with opcode=0 for 30 cycles → `clk_en` pulses every 5th cycle (6 pulses); `waiting`=`halted`=0.
- `div_load` with `div_value`=1 → ratio clamps to 2 and `clk_en` pulses every 2nd cycle. A load on the wrap cycle suppresses that tick.
- `step_mode`=1; `enter` bounces (0/1 alternating every 2 cycles) and then holds 0 for 10 cycles → exactly one `press` and one `clk_en`, about 7 cycles after the stable low begins; release produces nothing.
- opcode=OP_IN after a tick → `waiting`=1 and no `clk_en` for 100 cycles; a press → one `clk_en` with `waiting` 0 in the same cycle; then free-run resumes.
- opcode=OP_HALT → `halted`=1; a press with `resume`=0 is ignored; a press with `resume`=1 → RUN, with no `clk_en` on that cycle.
- Drive `reset`=0 mid-IO_WAIT and mid-debounce → all outputs 0 immediately; after release, RUN with div_reg=5 and no spurious `press`.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor constants: stalling opcodes and the step controller state set.
package proc_pkg;
  localparam logic [5:0] OP_IN   = 6'h1A;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IO_WAIT = 2'd1,
    HALT    = 2'd2
  } state_t;
endpackage

// File: rtl/button_debounce.sv
// Synchronises an active-low push-button, debounces it, and emits a one-cycle
// pulse on each accepted press (release is silent).
module button_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn_n,
  output logic o_press
);
  localparam int            CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          r_s1, r_s2, r_deb, r_deb_d, r_press;
  logic [CW-1:0] r_cnt;
  logic          w_diff;

  assign w_diff  = r_s2 ^ r_deb;
  assign o_press = r_press;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_deb   <= 1'b1;
      r_deb_d <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_btn_n;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      // falling edge of the accepted level only; release produces nothing
      r_press <= r_deb_d & ~r_deb;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/clock_step_ctrl.sv
// Processor advance-pulse generator: free-run divider, single-step on button,
// and stalls on input/halt opcodes until the operator presses enter.
module clock_step_ctrl import proc_pkg::*; #(
  parameter int              DIV_W       = 26,
  parameter int              DIV_DEFAULT = 25000000,
  parameter int              DEB_CYCLES  = 500000,
  parameter int              OP_W        = 6,
  parameter logic [OP_W-1:0] OP_IN       = proc_pkg::OP_IN,
  parameter logic [OP_W-1:0] OP_HALT     = proc_pkg::OP_HALT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enter,
  input  logic             step_mode,
  input  logic             resume,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic [OP_W-1:0]  opcode,
  output logic             clk_en,
  output logic             waiting,
  output logic             halted,
  output logic             press
);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_RST = (DIV_DEFAULT < 2) ? DIV_MIN : DIV_W'(DIV_DEFAULT);

  state_t           r_state;
  logic             r_clk_en, r_chk;
  logic [DIV_W-1:0] r_div, r_cnt;
  logic             w_press, w_stall, w_run, w_tick;
  logic [DIV_W-1:0] w_div_new;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_enter (
    .clock   (clock),
    .reset   (reset),
    .i_btn_n (enter),
    .o_press (w_press)
  );

  // r_chk marks the cycle after an advance, when the new opcode is valid
  assign w_stall   = r_chk && (r_state == RUN) && (opcode == OP_IN || opcode == OP_HALT);
  assign w_run     = (r_state == RUN) && !step_mode && !w_stall;
  assign w_tick    = w_run && !div_load && (r_cnt == r_div - 1'b1);
  assign w_div_new = (div_value < DIV_MIN) ? DIV_MIN : div_value;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div <= DIV_RST;
      r_cnt <= '0;
    end else if (div_load) begin
      r_div <= w_div_new;
      r_cnt <= '0;
    end else if (!w_run || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= RUN;
      r_clk_en <= 1'b0;
      r_chk    <= 1'b0;
    end else begin
      r_chk    <= r_clk_en;
      r_clk_en <= 1'b0;
      case (r_state)
        RUN: begin
          // opcode check wins over a coincident press or tick
          if (w_stall)
            r_state <= (opcode == OP_HALT) ? HALT : IO_WAIT;
          else
            r_clk_en <= step_mode ? w_press : w_tick;
        end
        IO_WAIT: begin
          if (w_press) begin
            r_state  <= RUN;
            r_clk_en <= 1'b1;
          end
        end
        HALT: begin
          if (w_press && resume) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign clk_en  = r_clk_en;
  assign waiting = (r_state == IO_WAIT);
  assign halted  = (r_state == HALT);
  assign press   = w_press;
endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed bench for clock_step_ctrl with DEB_CYCLES=4, DIV_DEFAULT=5.
module tb_clock_step_ctrl;
  logic        clock = 1'b0;
  logic        reset, enter, step_mode, resume, div_load;
  logic [25:0] div_value;
  logic [5:0]  opcode;
  logic        clk_en, waiting, halted, press;

  int n_chk = 0, n_fail = 0;
  int a_idx, a_en, a_pr, a_wt, a_ht, a_first, a_cons;
  logic a_prev;
  int cnt_en;

  always #5 clock = ~clock;

  clock_step_ctrl #(
    .DIV_W(26), .DIV_DEFAULT(5), .DEB_CYCLES(4), .OP_W(6),
    .OP_IN(6'h1A), .OP_HALT(6'h3F)
  ) dut (
    .clock(clock), .reset(reset), .enter(enter), .step_mode(step_mode),
    .resume(resume), .div_load(div_load), .div_value(div_value), .opcode(opcode),
    .clk_en(clk_en), .waiting(waiting), .halted(halted), .press(press)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    a_idx = 0; a_en = 0; a_pr = 0; a_wt = 0; a_ht = 0; a_first = 0; a_cons = 0;
    a_prev = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      a_idx++;
      if (clk_en) begin
        a_en++;
        if (a_first == 0) a_first = a_idx;
        if (a_prev) a_cons++;
      end
      a_prev = clk_en;
      if (press)   a_pr++;
      if (waiting) a_wt++;
      if (halted)  a_ht++;
    end
  endtask

  task automatic wait_en();
    int found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clock);
      if (clk_en) found = 1;
    end
    check("wait_en", found, 1);
  endtask

  task automatic load_div(input int v);
    div_value = 26'(v);
    div_load  = 1'b1;
    @(negedge clock);
    div_load  = 1'b0;
  endtask

  initial begin
    enter = 1'b1; step_mode = 1'b0; resume = 1'b0; div_load = 1'b0;
    div_value = '0; opcode = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clock); @(negedge clock);
    check("rst_clk_en", clk_en, 0);
    check("rst_waiting", waiting, 0);
    check("rst_halted", halted, 0);
    check("rst_press", press, 0);
    reset = 1'b1;

    // free-run at the default ratio
    clr(); run(30);
    check("fr_pulses", a_en, 6);
    check("fr_first", a_first, 5);
    check("fr_consec", a_cons, 0);
    check("fr_waiting", a_wt, 0);
    check("fr_halted", a_ht, 0);

    // ratio 1 clamps to 2
    load_div(1);
    clr(); run(20);
    check("div2_pulses", a_en, 10);
    check("div2_first", a_first, 2);
    check("div2_consec", a_cons, 0);

    // load coinciding with the wrap suppresses that tick
    wait_en();
    @(negedge clock);
    div_value = 26'd2; div_load = 1'b1;
    @(negedge clock);
    check("load_wrap_suppress", clk_en, 0);
    div_load = 1'b0;
    @(negedge clock);
    check("load_wrap_next0", clk_en, 0);
    @(negedge clock);
    check("load_wrap_tick", clk_en, 1);

    // single-step with a bouncing button
    step_mode = 1'b1;
    clr();
    for (int k = 0; k < 4; k++) begin
      enter = 1'b0; run(2);
      enter = 1'b1; run(2);
    end
    check("bounce_press", a_pr, 0);
    check("bounce_en", a_en, 0);
    enter = 1'b0;
    clr(); run(12);
    check("step_press", a_pr, 1);
    check("step_en", a_en, 1);
    check("step_en_idx", a_first, 8);
    enter = 1'b1;
    clr(); run(12);
    check("release_press", a_pr, 0);
    check("release_en", a_en, 0);

    // input-instruction stall
    step_mode = 1'b0;
    load_div(5);
    wait_en();
    opcode = 6'h1A;
    @(negedge clock); @(negedge clock);
    check("io_wait_enter", waiting, 1);
    clr(); run(100);
    check("io_wait_en", a_en, 0);
    check("io_wait_held", a_wt, 100);
    enter = 1'b0;
    cnt_en = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (clk_en) cnt_en++;
      if (i == 7) check("io_wait_pre", waiting, 1);
      if (i == 8) begin
        check("io_release_en", clk_en, 1);
        check("io_release_wait", waiting, 0);
        opcode = 6'h00;
      end
    end
    check("io_en_count", cnt_en, 1);
    enter = 1'b1;
    clr(); run(20);
    check("io_resume_pulses", a_en, 4);

    // halt, ignored press, then resume
    wait_en();
    opcode = 6'h3F;
    @(negedge clock); @(negedge clock);
    check("halt_enter", halted, 1);
    resume = 1'b0;
    enter = 1'b0;
    clr(); run(10);
    enter = 1'b1; run(10);
    check("halt_press_seen", a_pr, 1);
    check("halt_held", a_ht, 20);
    check("halt_en", a_en, 0);
    resume = 1'b1;
    enter = 1'b0;
    cnt_en = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (clk_en) cnt_en++;
      if (i == 7) check("halt_pre_resume", halted, 1);
      if (i == 8) begin
        check("halt_resumed", halted, 0);
        check("halt_resume_en", clk_en, 0);
        opcode = 6'h00;
      end
    end
    check("halt_resume_en_cnt", cnt_en, 0);
    enter = 1'b1; resume = 1'b0;

    // reset mid-stall and mid-debounce
    load_div(3);
    wait_en();
    opcode = 6'h1A;
    @(negedge clock); @(negedge clock); @(negedge clock);
    check("pre_rst_waiting", waiting, 1);
    enter = 1'b0;
    @(negedge clock); @(negedge clock); @(negedge clock);
    reset = 1'b0;
    #1;
    check("async_rst_waiting", waiting, 0);
    check("async_rst_halted", halted, 0);
    check("async_rst_clk_en", clk_en, 0);
    check("async_rst_press", press, 0);
    enter = 1'b1; opcode = 6'h00;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    clr(); run(20);
    check("post_rst_first", a_first, 5);
    check("post_rst_pulses", a_en, 4);
    check("post_rst_press", a_pr, 0);
    check("post_rst_waiting", a_wt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
